// File: rtl/index_write_arbiter.sv
// Round-robin arbiter for the palette-index frame-memory write port, with a full-screen clear.
// Optional macro VBLANK_GATE_EN: writer grants are only issued while vblank is high.
module index_write_arbiter #(
   parameter int unsigned ADDR_W   = 19,
   parameter int unsigned DATA_W   = 3,
   parameter int unsigned PIXELS   = 307200,
   parameter int unsigned BG_INDEX = 0
) (
   input  logic              iVGA_CLK,
   input  logic              iRST_n,
   input  logic              vblank,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic              clr_done,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wenable,
   output logic [7:0]        drop_cnt
);

   typedef enum logic [0:0] {StIdle, StClear} state_e;

   localparam logic [ADDR_W:0]   PixLimit = (ADDR_W + 1)'(PIXELS);
   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(PIXELS - 1);
   localparam logic [DATA_W-1:0] BgData   = DATA_W'(BG_INDEX);
   localparam logic              GrantA   = 1'b0;
   localparam logic              GrantB   = 1'b1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              last_grant_q, last_grant_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              wen_q, wen_d;
   logic              done_q, done_d;
   logic [7:0]        drop_q, drop_d;
   logic              gate_open;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

`ifdef VBLANK_GATE_EN
   assign gate_open = vblank;
`else
   logic unused_vblank;
   assign unused_vblank = vblank;
   assign gate_open     = 1'b1;
`endif

   assign sel_addr = b_ready ? b_addr : a_addr;
   assign sel_data = b_ready ? b_data : a_data;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      waddr_d      = waddr_q;
      wdata_d      = wdata_q;
      wen_d        = 1'b0;
      done_d       = 1'b0;
      drop_d       = drop_q;
      a_ready      = 1'b0;
      b_ready      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (clr_start) begin
               state_d = StClear;
               cnt_d   = '0;
            end else if (gate_open && !done_q) begin
               // The cycle carrying the final clear write still counts as busy.
               if (a_valid && (!b_valid || (last_grant_q == GrantB))) begin
                  a_ready = 1'b1;
               end else if (b_valid) begin
                  b_ready = 1'b1;
               end
            end

            if (a_ready || b_ready) begin
               last_grant_d = b_ready ? GrantB : GrantA;
               if ({1'b0, sel_addr} < PixLimit) begin
                  waddr_d = sel_addr;
                  wdata_d = sel_data;
                  wen_d   = 1'b1;
               end else if (drop_q != 8'hFF) begin
                  drop_d = drop_q + 8'd1;
               end
            end
         end

         StClear: begin
            waddr_d = cnt_q;
            wdata_d = BgData;
            wen_d   = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LastAddr) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         last_grant_q <= GrantB;
         waddr_q      <= '0;
         wdata_q      <= '0;
         wen_q        <= 1'b0;
         done_q       <= 1'b0;
         drop_q       <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
         wen_q        <= wen_d;
         done_q       <= done_d;
         drop_q       <= drop_d;
      end
   end

   assign mem_waddr   = waddr_q;
   assign mem_wdata   = wdata_q;
   assign mem_wenable = wen_q;
   assign clr_done    = done_q;
   assign clr_busy    = (state_q == StClear) || done_q;
   assign drop_cnt    = drop_q;

endmodule
